// File: rtl/battle_sequencer_pkg.sv
// battle_pkg: shared battle phase codes and HP widths
package battle_pkg;
    localparam int ENEMY_HP_W = 11;
    localparam int PLAYER_HP_W = 8;
    typedef enum logic [3:0] {
        S_MENU   = 4'b0000,
        S_ATTACK = 4'b0001,
        S_ENEMY  = 4'b0010,
        S_WIN    = 4'b0011,
        S_LOSE   = 4'b0100,
        S_IDLE   = 4'b1010
    } battle_state_t;
endpackage

// File: rtl/battle_sequencer_if.sv
// battle_sequencer_if: event pulses in, phase and HP status out
interface battle_sequencer_if;
    import battle_pkg::*;
    logic                   start_in;
    logic                   frame_tick_in;
    logic                   menu_finished_in;
    logic                   attack_finished_in;
    logic [ENEMY_HP_W-1:0]  attack_damage_in;
    logic                   player_hit_in;
    logic [PLAYER_HP_W-1:0] hit_damage_in;
    logic                   dodge_finished_in;
    logic [3:0]             state_out;
    logic                   phase_start_out;
    logic [ENEMY_HP_W-1:0]  enemy_hp_left_out;
    logic [PLAYER_HP_W-1:0] player_hp_out;
    logic [7:0]             turn_count_out;
    logic                   victory_out;
    logic                   game_over_out;
    modport master (
        output start_in, frame_tick_in, menu_finished_in, attack_finished_in, attack_damage_in,
               player_hit_in, hit_damage_in, dodge_finished_in,
        input  state_out, phase_start_out, enemy_hp_left_out, player_hp_out, turn_count_out,
               victory_out, game_over_out
    );
    modport slave (
        input  start_in, frame_tick_in, menu_finished_in, attack_finished_in, attack_damage_in,
               player_hit_in, hit_damage_in, dodge_finished_in,
        output state_out, phase_start_out, enemy_hp_left_out, player_hp_out, turn_count_out,
               victory_out, game_over_out
    );
endinterface

// File: rtl/hp_saturating_sub.sv
// hp_saturating_sub: HP register with load and subtract that clamps at zero
module hp_saturating_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_sub,
    input  logic [W-1:0] i_amount,
    output logic [W-1:0] o_hp,
    output logic         o_sub_zero
);
    logic [W-1:0] r_hp;
    assign o_sub_zero = i_amount >= r_hp;
    assign o_hp = r_hp;
    // load has priority; a subtract that would underflow lands on zero
    always_ff @(posedge clk)
        if (rst) r_hp <= '0;
        else if (i_load) r_hp <= i_load_val;
        else if (i_sub) r_hp <= o_sub_zero ? '0 : r_hp - i_amount;
endmodule

// File: rtl/battle_sequencer.sv
// battle_sequencer: battle phase FSM with HP tracking; optional enemy-turn timeout via BATTLE_TIMEOUT_EN
module battle_sequencer
    import battle_pkg::*;
#(
    parameter logic [ENEMY_HP_W-1:0]  ENEMY_HP_INIT  = 11'd192,
    parameter logic [PLAYER_HP_W-1:0] PLAYER_HP_INIT = 8'd20,
    parameter int                     PHASE_TIMEOUT  = 600
) (
    input logic               clk,
    input logic               rst,
    battle_sequencer_if.slave bus
);
    battle_state_t r_state, w_next;
    logic          r_phase;
    logic [7:0]    r_turn;
    logic          w_load, w_esub, w_psub, w_inc, w_e_zero, w_p_zero, w_timeout;
    logic [ENEMY_HP_W-1:0]  w_ehp;
    logic [PLAYER_HP_W-1:0] w_php;

    hp_saturating_sub #(.W(ENEMY_HP_W)) u_enemy_hp (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(ENEMY_HP_INIT),
        .i_sub(w_esub), .i_amount(bus.attack_damage_in), .o_hp(w_ehp), .o_sub_zero(w_e_zero)
    );

    hp_saturating_sub #(.W(PLAYER_HP_W)) u_player_hp (
        .clk(clk), .rst(rst), .i_load(w_load), .i_load_val(PLAYER_HP_INIT),
        .i_sub(w_psub), .i_amount(bus.hit_damage_in), .o_hp(w_php), .o_sub_zero(w_p_zero)
    );

`ifdef BATTLE_TIMEOUT_EN
    localparam int FW = $clog2(PHASE_TIMEOUT + 1);
    logic [FW-1:0] r_frames;
    assign w_timeout = bus.frame_tick_in && r_frames == FW'(PHASE_TIMEOUT - 1);
    // frame counter restarts on each entry to ENEMY and counts ticks while there
    always_ff @(posedge clk)
        if (rst) r_frames <= '0;
        else if (w_next == S_ENEMY && r_state != S_ENEMY) r_frames <= '0;
        else if (r_state == S_ENEMY && bus.frame_tick_in) r_frames <= r_frames + 1'b1;
`else
    assign w_timeout = 1'b0 & bus.frame_tick_in & (PHASE_TIMEOUT == 0);
`endif

    // next phase and HP/turn update strobes; a fatal hit beats dodge or timeout
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_esub = 1'b0;
        w_psub = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                w_load = bus.start_in;
                w_next = bus.start_in ? S_MENU : r_state;
            end
            S_MENU: w_next = bus.menu_finished_in ? S_ATTACK : S_MENU;
            S_ATTACK: begin
                w_esub = bus.attack_finished_in;
                w_next = !bus.attack_finished_in ? S_ATTACK : w_e_zero ? S_WIN : S_ENEMY;
            end
            S_ENEMY: begin
                w_psub = bus.player_hit_in;
                w_inc  = !(bus.player_hit_in && w_p_zero) && (bus.dodge_finished_in || w_timeout);
                w_next = (bus.player_hit_in && w_p_zero) ? S_LOSE : w_inc ? S_MENU : S_ENEMY;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // phase register, change strobe and saturating turn counter
    always_ff @(posedge clk)
        if (rst) begin
            r_state <= S_IDLE;
            r_phase <= 1'b0;
            r_turn  <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= w_next != r_state;
            r_turn  <= w_load ? '0 : (w_inc && r_turn != 8'hFF) ? r_turn + 8'd1 : r_turn;
        end

    assign bus.state_out         = r_state;
    assign bus.phase_start_out   = r_phase;
    assign bus.enemy_hp_left_out = w_ehp;
    assign bus.player_hp_out     = w_php;
    assign bus.turn_count_out    = r_turn;
    assign bus.victory_out       = r_state == S_WIN;
    assign bus.game_over_out     = r_state == S_LOSE;
endmodule

// File: doc/battle_sequencer.md
BATTLE_SEQUENCER -- requirements
Module: battle_sequencer

Interface
REQ-001 Parameter ENEMY_HP_INIT, default 11'd192, is the enemy HP loaded at battle start.
REQ-002 Parameter PLAYER_HP_INIT, default 8'd20, is the player HP loaded at battle start.
REQ-003 Parameter PHASE_TIMEOUT, default 600, is the enemy-turn limit in frames; it is used only with BATTLE_TIMEOUT_EN.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  level; begins or restarts a battle.
- frame_tick_in  in  1  one-cycle pulse per video frame.
- menu_finished_in  in  1  one-cycle pulse from the menu on player command.
- attack_finished_in  in  1  pulse ending the attack phase.
- attack_damage_in  in  11  damage applied with attack_finished_in.
- player_hit_in  in  1  pulse when the heart is hit.
- hit_damage_in  in  8  damage applied with player_hit_in.
- dodge_finished_in  in  1  pulse ending the enemy turn.
- state_out  out  4  current phase code, drives the menu's state input.
- phase_start_out  out  1  one-cycle pulse on every state_out change.
- enemy_hp_left_out  out  11  remaining enemy HP.
- player_hp_out  out  8  remaining player HP.
- turn_count_out  out  8  completed turns.
- victory_out  out  1  level, high in WIN.
- game_over_out  out  1  level, high in LOSE.

Function
REQ-005 States and codes SHALL be: IDLE=4'b1010, MENU=4'b0000, ATTACK=4'b0001, ENEMY=4'b0010, WIN=4'b0011, LOSE=4'b0100.
REQ-006 state_out SHALL be registered and equal the current state code.
REQ-007 IDLE -> MENU when start_in=1; on the same edge enemy_hp_left_out<=ENEMY_HP_INIT, player_hp_out<=PLAYER_HP_INIT, turn_count_out<=0.
REQ-008 MENU -> ATTACK on menu_finished_in; the pulse is ignored in every other state.
REQ-009 On attack_finished_in in ATTACK, enemy HP SHALL become enemy_hp - attack_damage_in, saturating at 0.
- If the result is 0 -> WIN.
- Otherwise -> ENEMY.
REQ-010 attack_finished_in outside ATTACK SHALL be ignored, with no HP change.
REQ-011 On player_hit_in in ENEMY, player HP SHALL become player_hp - hit_damage_in, saturating at 0; if the result is 0 -> LOSE.
REQ-012 dodge_finished_in in ENEMY SHALL move to MENU and increment turn_count_out, saturating at 255.
REQ-013 If a fatal player_hit_in and dodge_finished_in arrive in the same cycle, LOSE SHALL win: no turn increment, no MENU.
REQ-014 player_hit_in outside ENEMY SHALL be ignored.
REQ-015 WIN and LOSE are terminal; start_in=1 there SHALL reload HPs as in REQ-007 and go to MENU.
REQ-016 Every entry to MENU SHALL come from a non-MENU code, so the consumer always sees a state edge.
REQ-017 phase_start_out SHALL pulse exactly one cycle, on the cycle state_out first shows the new code.
REQ-018 All next-state and HP updates take effect one clock after the qualifying input is sampled.

Reset
REQ-019 rst=1 SHALL force, on the next edge, all of the following, with priority over all inputs, including mid-battle:
- state_out=IDLE
- phase_start_out=0
- enemy_hp_left_out=0
- player_hp_out=0
- turn_count_out=0
- victory_out=0
- game_over_out=0
- timeout counter=0

Configuration
REQ-020 With macro BATTLE_TIMEOUT_EN defined:
- A frame counter clears on ENEMY entry and counts frame_tick_in while in ENEMY.
- When it reaches PHASE_TIMEOUT, the block SHALL behave as if dodge_finished_in had arrived (REQ-012).
- A fatal hit in the same cycle still takes priority (REQ-013).
REQ-021 Without BATTLE_TIMEOUT_EN, no counter SHALL be synthesized, and ENEMY waits indefinitely for dodge_finished_in or a fatal hit.

Structure
REQ-022 Package battle_pkg SHALL hold the battle_state_t enum with the REQ-005 codes and the HP width constants; the game top and this block share it.
REQ-023 Sub-module hp_saturating_sub (parameterized width, load/subtract/saturate) SHALL be instantiated twice, once for enemy HP and once for player HP.

Verification
REQ-024 Start: rst, then start_in=1 -> state_out=0000 one cycle later, phase_start_out=1, enemy_hp_left_out=192, player_hp_out=20.
REQ-025 Full turn: menu_finished_in -> 0001; attack_finished_in with damage 50 -> enemy HP 142, state 0010; dodge_finished_in -> state 0000, turn_count_out=1.
REQ-026 Win: damage 200 against HP 142 -> enemy HP 0, state 0011, victory_out=1; a later menu_finished_in causes no change.
REQ-027 Lose race: in ENEMY with HP 5, player_hit_in with damage 9 and dodge_finished_in in the same cycle -> player HP 0, state 0100, game_over_out=1, turn count unchanged.
REQ-028 Reset mid-op: rst asserted in ATTACK -> next cycle state 1010 and all counters 0.
REQ-029 Timeout (BATTLE_TIMEOUT_EN, PHASE_TIMEOUT=3): three frame_tick_in pulses in ENEMY -> state 0000 and turn_count_out increments.
